nyq_interp: RTL and testbench
=============================

# nyq_interp

Polyphase Nyquist interpolation filter, the transmit-side counterpart of the decimating Nyquist filter. It accepts one 24-bit signed sample per frame of 8 clocks and emits 8 low-pass-filtered output samples per input, one per clock, for a 1:8 upsampling. It sits on the transmit chain, fed by an upstream block through a valid/ready handshake. It carries the standard 32-entry parameter memory, which holds the 32 filter coefficients.

## Interface
- ADDR_WIDTH, 5, parameter memory address width; depth is 2^ADDR_WIDTH = 32.
- MEM_WIDTH, 24, coefficient word width, signed Q1.23.
- IN_WIDTH, 24, input sample width, signed Q1.23.
- OUT_WIDTH, 24, output sample width, signed Q1.23.

Ports (clock and reset first):
- Clk_CI  in  1  clock, rising edge.
- Rst_RBI  in  1  reset, asynchronous, active-low.
- WrEn_SI  in  1  parameter write enable, active high.
- Addr_DI  in  ADDR_WIDTH  parameter address.
- PAR_In_DI  in  MEM_WIDTH  parameter write data.
- NYQ_In_DI  in  IN_WIDTH  input sample.
- NYQ_InValid_SI  in  1  input sample valid.
- NYQ_InReady_DO  out  1  block can accept a sample this cycle.
- NYQ_Out_DO  out  OUT_WIDTH  interpolated output sample, registered.
- NYQ_Valid_DO  out  1  NYQ_Out_DO is valid, registered.

## Operation
- Coefficient storage:
  - Memory h[0..31] is written on the clock edge when WrEn_SI=1.
  - Writes are allowed at any time, including mid-frame.
  - A written value is used from the next cycle's computation onward.
- Delay line: x0..x3, where x0 is the newest sample.
- Accept = NYQ_InValid_SI & NYQ_InReady_DO.
  - On accept: x3<=x2, x2<=x1, x1<=x0, x0<=NYQ_In_DI.
  - Samples presented when NYQ_InReady_DO=0 are ignored and not stored.
- FSM states:
  - IDLE: NYQ_InReady_DO=1. On accept, go to RUN with phase<=0.
  - RUN: phase counter p steps 0..7, one step per cycle. NYQ_InReady_DO=1 only when p=7.
  - At p=7 with accept: phase<=0, stay in RUN (seamless, no bubble).
  - At p=7 without accept: go to IDLE.
- Arithmetic, evaluated every RUN cycle for the current phase p:
  - y = sum over j=0..3 of h[8j+p]·xj.
  - Each product is 48-bit signed; the sum is 50-bit signed.
  - Result = arithmetic shift right by 23 (floor truncation, no rounding).
  - The result saturates to the range [0x800000, 0x7FFFFF].
- Output register:
  - When the FSM is in RUN, NYQ_Out_DO<=saturated y and NYQ_Valid_DO<=1.
  - Otherwise NYQ_Valid_DO<=0 and NYQ_Out_DO holds its last value.
- Idle behaviour: the delay line is retained across IDLE gaps and is not flushed. The filter state is continuous across gaps.

## Timing
- Reset (asynchronous, immediate):
  - NYQ_Out_DO=0, NYQ_Valid_DO=0.
  - Parameter memory, delay line and phase cleared to 0; FSM in IDLE.
  - NYQ_InReady_DO=1.
- Latency: for an accept at edge E0, phase p output is valid after edge E(1+p), for p=0..7. First output appears one cycle after accept.
- Continuous streaming: if NYQ_InValid_SI is held high, a sample is accepted every 8th cycle and NYQ_Valid_DO stays high without gaps.
- Underrun: if no accept occurs at p=7, NYQ_Valid_DO drops after the edge that follows phase 7's output. It stays low until 1 cycle after the next accept.
- Reset mid-frame: the frame is aborted. Outputs go to reset values immediately and coefficients must be rewritten.
- Simultaneous parameter write and accept: both take effect at the same edge, independently of each other.
- NYQ_InReady_DO is combinational from the FSM state and phase only. It does not depend on NYQ_InValid_SI.

## Structure
- Shared package/header (nyq_pkg): NYQ_PHASES=8, NYQ_TAPS=4, NYQ_FRAC=23, and the FSM state encodings (IDLE=0, RUN=1).
- Shared with the decimator: the coefficient Q-format and saturation bounds.
- Sub-module nyq_dot4_sat, purely combinational:
  - Inputs: 4 coefficients and 4 samples.
  - Output: the saturated 24-bit result.
  - Instantiated once.
- The top level contains the parameter memory, delay line, FSM/phase counter and output register.

## Test plan
- Reset:
  - Assert Rst_RBI with random inputs present -> NYQ_Out_DO=0, NYQ_Valid_DO=0, NYQ_InReady_DO=1.
  - Memory readback via impulse test gives all-zero outputs.
- Impulse response:
  - Setup: h[k]=k·0x010000. Accept 0x400000, then 0, 0, 0 back-to-back.
  - Expect 32 consecutive valid outputs equal to k·0x008000 (0x000000, 0x008000 … 0x0F8000), then NYQ_Valid_DO=0.
- Saturation:
  - All h=0x7FFFFF with 4 inputs of 0x7FFFFF -> outputs 0x7FFFFF.
  - All h=0x7FFFFF with 4 inputs of 0x800000 -> outputs 0x800000.
- Handshake and gaps:
  - With NYQ_InValid_SI held high, NYQ_InReady_DO pulses 1 in every 8 cycles and NYQ_Valid_DO stays high continuously.
  - Drop valid for 5 cycles after a frame -> FSM returns to IDLE, NYQ_Valid_DO=0 for those cycles.
  - The next frame's outputs reflect the retained delay line.
- Reset mid-frame: assert Rst_RBI at phase 3 -> outputs go to 0 the same cycle, the FSM is in IDLE after release, and no further valids occur.
- Live coefficient write:
  - Setup: h[2] changed from 0 to 0x200000 while phase 0 is computed, with x0=0x400000 and all other h=0.
  - Expect the phase 2 output of the same frame = 0x100000.

Source files
------------

// File: rtl/nyq_pkg.sv
// rtl/nyq_pkg.sv - shared constants, FSM encoding and saturation helper for the Nyquist filters
//
// Purpose: common definitions for the Nyquist interpolator and decimator:
//   polyphase geometry, Q1.23 coefficient format, saturation bounds,
//   FSM state encoding and a saturating narrowing helper.
// Ports: none (package).

package nyq_pkg;

    localparam int NYQ_PHASES = 8;
    localparam int NYQ_TAPS   = 4;
    localparam int NYQ_FRAC   = 23;

    localparam int NYQ_PH_W   = 3;   // log2(NYQ_PHASES)
    localparam int NYQ_TAP_W  = 2;   // log2(NYQ_TAPS)
    localparam int NYQ_DATA_W = 24;  // Q1.23 coefficient and sample width
    localparam int NYQ_PROD_W = 48;
    localparam int NYQ_SUM_W  = 50;

    localparam logic signed [NYQ_SUM_W-1:0] NYQ_SAT_MAX = 50'sh7FFFFF;
    localparam logic signed [NYQ_SUM_W-1:0] NYQ_SAT_MIN = -50'sh800000;

    typedef enum logic {
        NYQ_IDLE = 1'b0,
        NYQ_RUN  = 1'b1
    } nyq_state_e;

    // Clamp a wide signed value into the Q1.23 output range.
    function automatic logic [NYQ_DATA_W-1:0] nyq_sat(input logic signed [NYQ_SUM_W-1:0] v);
        if (v > NYQ_SAT_MAX) begin
            return 24'h7FFFFF;
        end else if (v < NYQ_SAT_MIN) begin
            return 24'h800000;
        end else begin
            return v[NYQ_DATA_W-1:0];
        end
    endfunction

endpackage

// File: rtl/nyq_dot4_sat.sv
// rtl/nyq_dot4_sat.sv - 4-tap signed dot product with floor shift and saturation
//
// Purpose: y = sat( (sum_j coef[j]*samp[j]) >>> NYQ_FRAC ), purely combinational.
// Ports:
//   i_coef  in   4 x 24  signed Q1.23 coefficients
//   i_samp  in   4 x 24  signed Q1.23 samples
//   o_y     out  24      saturated Q1.23 result

module nyq_dot4_sat
    import nyq_pkg::*;
(
    input  logic [NYQ_TAPS-1:0][NYQ_DATA_W-1:0] i_coef,
    input  logic [NYQ_TAPS-1:0][NYQ_DATA_W-1:0] i_samp,
    output logic [NYQ_DATA_W-1:0]               o_y
);

    logic signed [NYQ_PROD_W-1:0] w_prod [NYQ_TAPS];
    logic signed [NYQ_SUM_W-1:0]  w_sum;
    logic signed [NYQ_SUM_W-1:0]  w_shift;

    // Operands are sign-extended to the full product width so the multiply
    // is exact in 48 bits.
    for (genvar g = 0; g < NYQ_TAPS; g++) begin : g_prod
        assign w_prod[g] = $signed({{(NYQ_PROD_W-NYQ_DATA_W){i_coef[g][NYQ_DATA_W-1]}}, i_coef[g]})
                         * $signed({{(NYQ_PROD_W-NYQ_DATA_W){i_samp[g][NYQ_DATA_W-1]}}, i_samp[g]});
    end

    always_comb begin
        w_sum = '0;
        for (int j = 0; j < NYQ_TAPS; j++) begin
            w_sum = w_sum + {{(NYQ_SUM_W-NYQ_PROD_W){w_prod[j][NYQ_PROD_W-1]}}, w_prod[j]};
        end
    end

    // Arithmetic shift gives floor truncation toward minus infinity.
    assign w_shift = w_sum >>> NYQ_FRAC;
    assign o_y     = nyq_sat(w_shift);

endmodule

// File: rtl/nyq_interp.sv
// rtl/nyq_interp.sv - 1:8 polyphase Nyquist interpolation filter
//
// Purpose: accepts one Q1.23 sample per 8-clock frame over a valid/ready
//   handshake and emits 8 filtered samples, one per clock.
// Ports:
//   Clk_CI          in   1           clock, rising edge
//   Rst_RBI         in   1           asynchronous active-low reset
//   WrEn_SI         in   1           coefficient write enable
//   Addr_DI         in   ADDR_WIDTH  coefficient address
//   PAR_In_DI       in   MEM_WIDTH   coefficient write data
//   NYQ_In_DI       in   IN_WIDTH    input sample
//   NYQ_InValid_SI  in   1           input sample valid
//   NYQ_InReady_DO  out  1           sample can be accepted this cycle
//   NYQ_Out_DO      out  OUT_WIDTH   registered output sample
//   NYQ_Valid_DO    out  1           registered output valid

module nyq_interp
    import nyq_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int MEM_WIDTH  = 24,
    parameter int IN_WIDTH   = 24,
    parameter int OUT_WIDTH  = 24
) (
    input  logic                  Clk_CI,
    input  logic                  Rst_RBI,
    input  logic                  WrEn_SI,
    input  logic [ADDR_WIDTH-1:0] Addr_DI,
    input  logic [MEM_WIDTH-1:0]  PAR_In_DI,
    input  logic [IN_WIDTH-1:0]   NYQ_In_DI,
    input  logic                  NYQ_InValid_SI,
    output logic                  NYQ_InReady_DO,
    output logic [OUT_WIDTH-1:0]  NYQ_Out_DO,
    output logic                  NYQ_Valid_DO
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [MEM_WIDTH-1:0]               r_mem [DEPTH];
    logic [NYQ_TAPS-1:0][IN_WIDTH-1:0]  r_x;
    nyq_state_e                         r_state;
    logic [NYQ_PH_W-1:0]                r_phase;
    logic [OUT_WIDTH-1:0]               r_out;
    logic                               r_valid;

    logic                               w_accept;
    logic [NYQ_TAPS-1:0][MEM_WIDTH-1:0] w_coef;
    logic [OUT_WIDTH-1:0]               w_y;

    // Ready depends only on state and phase, never on the upstream valid.
    assign NYQ_InReady_DO = (r_state == NYQ_IDLE) || (r_phase == NYQ_PH_W'(NYQ_PHASES - 1));
    assign w_accept       = NYQ_InValid_SI && NYQ_InReady_DO;

    // Coefficient memory; writes are independent of the datapath and may
    // land mid-frame.
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (WrEn_SI) begin
            r_mem[Addr_DI] <= PAR_In_DI;
        end
    end

    // Tap j of phase p uses h[8j+p]: the tap index forms the upper address bits.
    for (genvar g = 0; g < NYQ_TAPS; g++) begin : g_coef
        assign w_coef[g] = r_mem[{NYQ_TAP_W'(g), r_phase}];
    end

    // Delay line, x0 newest; retained across idle gaps.
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            r_x <= '0;
        end else if (w_accept) begin
            r_x <= {r_x[NYQ_TAPS-2:0], NYQ_In_DI};
        end
    end

    nyq_dot4_sat u_dot (
        .i_coef (w_coef),
        .i_samp (r_x),
        .o_y    (w_y)
    );

    // Frame FSM with phase counter. Accepting at the last phase restarts the
    // frame without a bubble.
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            r_state <= NYQ_IDLE;
            r_phase <= '0;
        end else begin
            case (r_state)
                NYQ_IDLE: begin
                    if (w_accept) begin
                        r_state <= NYQ_RUN;
                        r_phase <= '0;
                    end
                end
                NYQ_RUN: begin
                    if (r_phase == NYQ_PH_W'(NYQ_PHASES - 1)) begin
                        r_phase <= '0;
                        if (!w_accept) begin
                            r_state <= NYQ_IDLE;
                        end
                    end else begin
                        r_phase <= r_phase + 1'b1;
                    end
                end
                default: begin
                    r_state <= NYQ_IDLE;
                    r_phase <= '0;
                end
            endcase
        end
    end

    // Output register holds its last value while idle.
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            r_out   <= '0;
            r_valid <= 1'b0;
        end else if (r_state == NYQ_RUN) begin
            r_out   <= w_y;
            r_valid <= 1'b1;
        end else begin
            r_valid <= 1'b0;
        end
    end

    assign NYQ_Out_DO   = r_out;
    assign NYQ_Valid_DO = r_valid;

endmodule

// File: tb/tb_nyq_interp.sv
// tb/tb_nyq_interp.sv - self-checking bench for nyq_interp against an integer reference model

module tb_nyq_interp;

    logic        Clk_CI = 1'b0;
    logic        Rst_RBI;
    logic        WrEn_SI;
    logic [4:0]  Addr_DI;
    logic [23:0] PAR_In_DI;
    logic [23:0] NYQ_In_DI;
    logic        NYQ_InValid_SI;
    logic        NYQ_InReady_DO;
    logic [23:0] NYQ_Out_DO;
    logic        NYQ_Valid_DO;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model state: coefficients, delay line, frame position.
    int          m_h [32];
    int          m_x [4];
    bit          m_run;
    int          m_ph;
    logic [23:0] m_out;
    bit          m_val;

    nyq_interp dut (
        .Clk_CI         (Clk_CI),
        .Rst_RBI        (Rst_RBI),
        .WrEn_SI        (WrEn_SI),
        .Addr_DI        (Addr_DI),
        .PAR_In_DI      (PAR_In_DI),
        .NYQ_In_DI      (NYQ_In_DI),
        .NYQ_InValid_SI (NYQ_InValid_SI),
        .NYQ_InReady_DO (NYQ_InReady_DO),
        .NYQ_Out_DO     (NYQ_Out_DO),
        .NYQ_Valid_DO   (NYQ_Valid_DO)
    );

    always #5 Clk_CI = ~Clk_CI;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int sx24(input logic [23:0] v);
        return int'($signed(v));
    endfunction

    // Filter output for phase p from the model's coefficients and delay line.
    function automatic logic [23:0] ref_y(input int p);
        longint acc;
        acc = 0;
        for (int j = 0; j < 4; j++) begin
            acc += longint'(m_h[8 * j + p]) * longint'(m_x[j]);
        end
        acc = acc >>> 23;
        if (acc > 64'sd8388607) return 24'h7FFFFF;
        if (acc < -64'sd8388608) return 24'h800000;
        return acc[23:0];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_h[i] = 0;
        for (int j = 0; j < 4; j++) m_x[j] = 0;
        m_run = 0;
        m_ph  = 0;
        m_out = '0;
        m_val = 0;
    endtask

    // One clock: drive inputs at the falling edge, advance the model across
    // the rising edge, compare at the next falling edge.
    task automatic step(input bit v, input logic [23:0] d,
                        input bit we, input logic [4:0] a, input logic [23:0] wd);
        bit rdy;
        bit acc;
        NYQ_InValid_SI = v;
        NYQ_In_DI      = d;
        WrEn_SI        = we;
        Addr_DI        = a;
        PAR_In_DI      = wd;
        rdy = !m_run || (m_ph == 7);
        acc = v && rdy;
        #1;
        chk("ready", {31'd0, NYQ_InReady_DO}, {31'd0, rdy});
        if (m_run) begin
            m_out = ref_y(m_ph);
            m_val = 1;
        end else begin
            m_val = 0;
        end
        if (we) m_h[a] = sx24(wd);
        if (acc) begin
            for (int j = 3; j > 0; j--) m_x[j] = m_x[j-1];
            m_x[0] = sx24(d);
        end
        if (!m_run) begin
            if (acc) begin
                m_run = 1;
                m_ph  = 0;
            end
        end else if (m_ph == 7) begin
            m_ph = 0;
            if (!acc) m_run = 0;
        end else begin
            m_ph++;
        end
        @(posedge Clk_CI);
        @(negedge Clk_CI);
        chk("out", {8'd0, NYQ_Out_DO}, {8'd0, m_out});
        chk("valid", {31'd0, NYQ_Valid_DO}, {31'd0, m_val});
    endtask

    task automatic idle_step();
        step(0, $urandom, 0, 5'd0, 24'd0);
    endtask

    task automatic write_coef(input logic [4:0] a, input logic [23:0] wd);
        step(0, $urandom, 1, a, wd);
    endtask

    task automatic do_reset();
        @(negedge Clk_CI);
        Rst_RBI = 1'b0;
        #1;
        model_reset();
        chk("rst_out", {8'd0, NYQ_Out_DO}, 32'd0);
        chk("rst_valid", {31'd0, NYQ_Valid_DO}, 32'd0);
        chk("rst_ready", {31'd0, NYQ_InReady_DO}, 32'd1);
        @(negedge Clk_CI);
        Rst_RBI = 1'b1;
    endtask

    initial begin
        int guard;
        logic [23:0] k24;

        // Reset with random inputs present.
        Rst_RBI = 1'b0;
        model_reset();
        repeat (4) begin
            WrEn_SI        = $urandom;
            Addr_DI        = $urandom;
            PAR_In_DI      = $urandom;
            NYQ_In_DI      = $urandom;
            NYQ_InValid_SI = $urandom;
            @(negedge Clk_CI);
            chk("por_out", {8'd0, NYQ_Out_DO}, 32'd0);
            chk("por_valid", {31'd0, NYQ_Valid_DO}, 32'd0);
            chk("por_ready", {31'd0, NYQ_InReady_DO}, 32'd1);
        end
        Rst_RBI = 1'b1;

        // Cleared memory: impulse yields zeros.
        step(1, 24'h400000, 0, 5'd0, 24'd0);
        repeat (10) idle_step();

        // Impulse response with h[k] = k*0x010000.
        do_reset();
        for (int k = 0; k < 32; k++) begin
            k24 = 24'(k * 32'h010000);
            write_coef(5'(k), k24);
        end
        step(1, 24'h400000, 0, 5'd0, 24'd0);
        for (int f = 0; f < 3; f++) begin
            repeat (7) idle_step();
            step(1, 24'h000000, 0, 5'd0, 24'd0);
        end
        for (int p = 0; p < 8; p++) begin
            idle_step();
            if (p == 7) chk("imp_last", {8'd0, NYQ_Out_DO}, 32'h0F8000);
        end
        repeat (3) idle_step();

        // Saturation, positive then negative.
        for (int s = 0; s < 2; s++) begin
            do_reset();
            for (int k = 0; k < 32; k++) write_coef(5'(k), 24'h7FFFFF);
            for (int f = 0; f < 4; f++) begin
                step(1, (s == 0) ? 24'h7FFFFF : 24'h800000, 0, 5'd0, 24'd0);
                repeat (7) idle_step();
            end
            idle_step();
            chk(s == 0 ? "sat_pos" : "sat_neg", {8'd0, NYQ_Out_DO},
                (s == 0) ? 32'h7FFFFF : 32'h800000);
            repeat (10) idle_step();
        end

        // Streaming with valid held high, then a gap, then a resumed frame.
        do_reset();
        for (int k = 0; k < 32; k++) write_coef(5'(k), 24'($urandom_range(0, 24'hFFFFFF)));
        repeat (48) step(1, $urandom, 0, 5'd0, 24'd0);
        repeat (13) idle_step();
        step(1, $urandom, 0, 5'd0, 24'd0);
        repeat (12) idle_step();

        // Reset in the middle of a frame at phase 3.
        guard = 0;
        step(1, $urandom, 0, 5'd0, 24'd0);
        while (!(m_run && m_ph == 3) && guard < 50) begin
            step(1, $urandom, 0, 5'd0, 24'd0);
            guard++;
        end
        chk("midrst_reached", {31'd0, (m_run && m_ph == 3)}, 32'd1);
        #2;
        Rst_RBI = 1'b0;
        #1;
        chk("midrst_out", {8'd0, NYQ_Out_DO}, 32'd0);
        chk("midrst_valid", {31'd0, NYQ_Valid_DO}, 32'd0);
        chk("midrst_ready", {31'd0, NYQ_InReady_DO}, 32'd1);
        model_reset();
        @(negedge Clk_CI);
        Rst_RBI = 1'b1;
        repeat (10) idle_step();

        // Live coefficient write during phase 0.
        step(1, 24'h400000, 0, 5'd0, 24'd0);
        step(0, 24'd0, 1, 5'd2, 24'h200000);
        idle_step();
        idle_step();
        chk("live_h2", {8'd0, NYQ_Out_DO}, 32'h100000);
        repeat (8) idle_step();

        // Random traffic with random coefficient writes.
        for (int k = 0; k < 32; k++) write_coef(5'(k), 24'($urandom));
        for (int c = 0; c < 1500; c++) begin
            step(($urandom_range(0, 9) < 7), $urandom,
                 ($urandom_range(0, 9) == 0), 5'($urandom), 24'($urandom));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
